// File: rtl/game_state_controller_pkg.sv
// game_state_controller_pkg: shared game-flow encodings, widths and frog start position
package game_state_controller_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;
  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 4;
  localparam logic [9:0] FROG_START_X = 10'd304;
  localparam logic [8:0] FROG_START_Y = 9'd448;
  function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v);
    return v + LEVEL_W'(~&v);
  endfunction
endpackage

// File: rtl/game_state_controller_frame_countdown.sv
// frame_countdown: loadable down-counter stepped by tick, zero flags the terminal tick
module frame_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    zero  = tick && !load && cnt_q == W'(1);
    cnt_d = load ? load_val : (tick && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/game_state_controller.sv
// game_state_controller: Frogger lives/level/death/game-over flow with respawn guard window
module game_state_controller
  import game_state_controller_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_Y        = 0,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Start,
  input  logic                i_Frame_Tick,
  input  logic                i_Has_Collided,
  input  logic [8:0]          i_Frog_Y,
  output logic [1:0]          o_State,
  output logic [LIVES_W-1:0]  o_Lives,
  output logic [LEVEL_W-1:0]  o_Level,
  output logic                o_Freeze,
  output logic                o_Frog_Respawn,
  output logic                o_Game_Over
);
  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 respawn_q, respawn_d;
  logic [2:0]           guard_q, guard_d;
  logic                 armed, hit, win, start, death_zero;
  // the respawn cycle itself is also blind: the frog still sits at its old position
  always_comb begin
    armed     = state_q == PLAY && !respawn_q && guard_q == '0;
    hit       = armed && i_Has_Collided;
    win       = armed && !i_Has_Collided && i_Frog_Y <= 9'(WIN_Y);
    start     = i_Start && (state_q == IDLE || state_q == OVER);
    guard_d   = respawn_q ? 3'(GUARD_CYCLES) : guard_q - 3'(|guard_q);
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    respawn_d = 1'b0;
    if (start) begin
      state_d   = PLAY;
      lives_d   = LIVES_W'(LIVES_INIT);
      level_d   = '0;
      respawn_d = 1'b1;
    end else if (hit) begin
      state_d = DYING;
      lives_d = lives_q - LIVES_W'(|lives_q);
    end else if (win) begin
      level_d   = sat_inc(level_q);
      respawn_d = 1'b1;
    end else if (state_q == DYING && death_zero) begin
      state_d   = lives_q == '0 ? OVER : PLAY;
      respawn_d = lives_q != '0;
    end
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      lives_q   <= LIVES_W'(LIVES_INIT);
      level_q   <= '0;
      respawn_q <= 1'b0;
      guard_q   <= '0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      respawn_q <= respawn_d;
      guard_q   <= guard_d;
    end
  end
  frame_countdown #(.W(8)) u_death (
    .clk      (i_Clk),
    .rst      (i_Reset),
    .load     (hit),
    .load_val (8'(DEATH_FRAMES)),
    .tick     (i_Frame_Tick && state_q == DYING),
    .zero     (death_zero)
  );
  assign o_State        = state_q;
  assign o_Lives        = lives_q;
  assign o_Level        = level_q;
  assign o_Frog_Respawn = respawn_q;
  assign o_Freeze       = state_q != PLAY;
  assign o_Game_Over    = state_q == OVER;
endmodule
